// File: rtl/sensor_display_feeder_pkg.sv
// -----------------------------------------------------------------------------
// sensor_display_feeder_pkg
// Purpose : shared types and constants for the sensor display feeder.
//           - scale_state_t : states of the shared scaler FSM
//           - HUM_MAX       : humidity display ceiling in percent
//           - NUM_W         : width of the numbers handed to the LCD controller
// -----------------------------------------------------------------------------
package sensor_display_feeder_pkg;

  localparam int HUM_MAX = 100;
  localparam int NUM_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SCALE_HUM = 2'd1,
    ST_SCALE_BAT = 2'd2
  } scale_state_t;

endpackage : sensor_display_feeder_pkg

// File: rtl/sensor_display_feeder_avg_window.sv
// -----------------------------------------------------------------------------
// avg_window
// Purpose : boxcar average over 2^AVG_LOG2 consecutive accepted samples of one
//           channel. The finished average is held in a pending register until
//           the scaler consumes it; a newer average overwrites an unconsumed one.
// Ports   :
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   i_valid    in   sample strobe, one sample per high cycle
//   i_raw      in   RAW_BITS sample
//   i_clear    in   scaler has consumed the pending average
//   o_pending  out  an unconsumed average is available
//   o_avg      out  latest completed average (floor)
// -----------------------------------------------------------------------------
module avg_window #(
  parameter int RAW_BITS = 12,
  parameter int AVG_LOG2 = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_valid,
  input  logic [RAW_BITS-1:0] i_raw,
  input  logic                i_clear,
  output logic                o_pending,
  output logic [RAW_BITS-1:0] o_avg
);

  localparam int SUM_W = RAW_BITS + AVG_LOG2;

  logic [SUM_W-1:0]    r_sum;
  logic [AVG_LOG2-1:0] r_cnt;
  logic [SUM_W-1:0]    w_sum_next;
  logic                w_last;
  logic                w_done;

  // The current sample is folded in before the shift, so the window-completing
  // sample belongs to the window it closes.
  assign w_sum_next = r_sum + SUM_W'(i_raw);
  assign w_last     = (r_cnt == {AVG_LOG2{1'b1}});
  assign w_done     = i_valid & w_last;

  // Accumulate samples and latch the average when the window closes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sum <= {SUM_W{1'b0}};
      r_cnt <= {AVG_LOG2{1'b0}};
      o_avg <= {RAW_BITS{1'b0}};
    end else if (w_done) begin
      o_avg <= w_sum_next[SUM_W-1:AVG_LOG2];
      r_sum <= {SUM_W{1'b0}};
      r_cnt <= {AVG_LOG2{1'b0}};
    end else if (i_valid) begin
      r_sum <= w_sum_next;
      r_cnt <= r_cnt + AVG_LOG2'(1);
    end
  end

  // Pending flag: a freshly completed window wins over a same-cycle clear so
  // the new average is never lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_pending <= 1'b0;
    end else if (w_done) begin
      o_pending <= 1'b1;
    end else if (i_clear) begin
      o_pending <= 1'b0;
    end
  end

endmodule : avg_window

// File: rtl/sensor_display_feeder.sv
// -----------------------------------------------------------------------------
// sensor_display_feeder
// Purpose : averages humidity and battery ADC samples, scales them to percent
//           and millivolts with one shared multiplier, and holds the results
//           stable for the LCD1602 controller. Also delays the controller's
//           ready until the LCD power-on settling time has elapsed.
// Ports   :
//   clk        in   system clock
//   reset      in   synchronous, active-high reset
//   hum_valid  in   humidity sample strobe
//   hum_raw    in   humidity sample
//   bat_valid  in   battery sample strobe
//   bat_raw    in   battery sample
//   number1    out  humidity percent 0..100
//   number2    out  battery millivolts
//   ready_o    out  LCD ready, sticky high after POWERUP_CYCLES
//   update_o   out  one-cycle pulse per write of number1/number2
// -----------------------------------------------------------------------------
module sensor_display_feeder
  import sensor_display_feeder_pkg::*;
#(
  parameter int RAW_BITS       = 12,
  parameter int AVG_LOG2       = 3,
  parameter int VREF_MV        = 3300,
  parameter int POWERUP_CYCLES = 2500000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                hum_valid,
  input  logic [RAW_BITS-1:0] hum_raw,
  input  logic                bat_valid,
  input  logic [RAW_BITS-1:0] bat_raw,
  output logic [NUM_W-1:0]    number1,
  output logic [NUM_W-1:0]    number2,
  output logic                ready_o,
  output logic                update_o
);

  localparam int          PROD_W = 32;
  localparam int          PU_W   = $clog2(POWERUP_CYCLES + 1);
  localparam logic [31:0] ROUND  = 32'd1 << (RAW_BITS - 1);

  scale_state_t        r_state;
  logic [PU_W-1:0]     r_pu_cnt;

  logic                w_hum_pending;
  logic                w_bat_pending;
  logic [RAW_BITS-1:0] w_hum_avg;
  logic [RAW_BITS-1:0] w_bat_avg;
  logic                w_hum_clear;
  logic                w_bat_clear;
  logic [PROD_W-1:0]   w_mul_a;
  logic [PROD_W-1:0]   w_mul_k;
  logic [PROD_W-1:0]   w_product;
  logic [PROD_W-1:0]   w_rounded;
  logic [NUM_W-1:0]    w_hum_scaled;
  logic [NUM_W-1:0]    w_bat_scaled;

  avg_window #(.RAW_BITS(RAW_BITS), .AVG_LOG2(AVG_LOG2)) u_hum_avg (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (hum_valid),
    .i_raw     (hum_raw),
    .i_clear   (w_hum_clear),
    .o_pending (w_hum_pending),
    .o_avg     (w_hum_avg)
  );

  avg_window #(.RAW_BITS(RAW_BITS), .AVG_LOG2(AVG_LOG2)) u_bat_avg (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (bat_valid),
    .i_raw     (bat_raw),
    .i_clear   (w_bat_clear),
    .o_pending (w_bat_pending),
    .o_avg     (w_bat_avg)
  );

  // A scale state consumes its channel's pending average on the edge it writes.
  assign w_hum_clear = (r_state == ST_SCALE_HUM);
  assign w_bat_clear = (r_state == ST_SCALE_BAT);

  // Shared multiplier: operand select by state, round-half-up, then clamp.
  always_comb begin
    w_mul_a = {PROD_W{1'b0}};
    w_mul_k = {PROD_W{1'b0}};
    if (r_state == ST_SCALE_BAT) begin
      w_mul_a = PROD_W'(w_bat_avg);
      w_mul_k = PROD_W'(VREF_MV);
    end else begin
      w_mul_a = PROD_W'(w_hum_avg);
      w_mul_k = PROD_W'(HUM_MAX);
    end
    w_product = w_mul_a * w_mul_k;
    w_rounded = (w_product + ROUND) >> RAW_BITS;
    if (w_rounded > PROD_W'(HUM_MAX)) begin
      w_hum_scaled = NUM_W'(HUM_MAX);
    end else begin
      w_hum_scaled = w_rounded[NUM_W-1:0];
    end
    if (w_rounded > PROD_W'({NUM_W{1'b1}})) begin
      w_bat_scaled = {NUM_W{1'b1}};
    end else begin
      w_bat_scaled = w_rounded[NUM_W-1:0];
    end
  end

  // Scaler FSM with registered display outputs; humidity is served first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      number1  <= {NUM_W{1'b0}};
      number2  <= {NUM_W{1'b0}};
      update_o <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          update_o <= 1'b0;
          if (w_hum_pending) begin
            r_state <= ST_SCALE_HUM;
          end else if (w_bat_pending) begin
            r_state <= ST_SCALE_BAT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCALE_HUM: begin
          number1  <= w_hum_scaled;
          update_o <= 1'b1;
          if (w_bat_pending) begin
            r_state <= ST_SCALE_BAT;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_SCALE_BAT: begin
          number2  <= w_bat_scaled;
          update_o <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: begin
          update_o <= 1'b0;
          r_state  <= ST_IDLE;
        end
      endcase
    end
  end

  // Power-up timer: ready rises on the POWERUP_CYCLES-th edge after reset
  // release; the counter saturates so ready stays high.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pu_cnt <= {PU_W{1'b0}};
      ready_o  <= 1'b0;
    end else begin
      if (r_pu_cnt != PU_W'(POWERUP_CYCLES)) begin
        r_pu_cnt <= r_pu_cnt + PU_W'(1);
      end
      if (r_pu_cnt >= PU_W'(POWERUP_CYCLES - 1)) begin
        ready_o <= 1'b1;
      end
    end
  end

endmodule : sensor_display_feeder

// File: tb/tb_sensor_display_feeder.sv
// -----------------------------------------------------------------------------
// tb_sensor_display_feeder
// Directed scenarios for power-up, scaling, clamping, simultaneous completion,
// reset mid-window and back-to-back windows, followed by randomized traffic
// checked against a queue-based averaging model.
// -----------------------------------------------------------------------------
module tb_sensor_display_feeder;

  localparam int RAW_BITS = 12;
  localparam int AVG_LOG2 = 3;
  localparam int VREF_MV  = 3300;
  localparam int PU       = 16;
  localparam int WIN      = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        hum_valid = 1'b0;
  logic [11:0] hum_raw = 12'd0;
  logic        bat_valid = 1'b0;
  logic [11:0] bat_raw = 12'd0;
  logic [15:0] number1;
  logic [15:0] number2;
  logic        ready_o;
  logic        update_o;

  int checks = 0;
  int failures = 0;
  int hum_q[$];
  int bat_q[$];
  int exp_n1 = 0;
  int exp_n2 = 0;
  int upd_cnt = 0;
  int tick_no = 0;
  int upd_ticks[$];
  int upd_vals[$];
  int start_tick;

  sensor_display_feeder #(
    .RAW_BITS(RAW_BITS), .AVG_LOG2(AVG_LOG2),
    .VREF_MV(VREF_MV), .POWERUP_CYCLES(PU)
  ) dut (
    .clk(clk), .reset(reset),
    .hum_valid(hum_valid), .hum_raw(hum_raw),
    .bat_valid(bat_valid), .bat_raw(bat_raw),
    .number1(number1), .number2(number2),
    .ready_o(ready_o), .update_o(update_o)
  );

  always #5 clk = ~clk;

  // Display value for an average: round(avg*K/4096) half-up, clamped.
  function automatic int scale(input int avg, input int k, input int maxv);
    longint v;
    v = (longint'(avg) * longint'(k) + 64'd2048) / 64'd4096;
    if (v > maxv) v = maxv;
    return int'(v);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, update the model at the edge, settle at negedge.
  task automatic tick(input logic hv, input logic [11:0] hr, input logic bv, input logic [11:0] br);
    hum_valid = hv; hum_raw = hr; bat_valid = bv; bat_raw = br;
    @(posedge clk);
    if (reset) begin
      hum_q.delete(); bat_q.delete(); exp_n1 = 0; exp_n2 = 0;
    end else begin
      if (hv) begin
        hum_q.push_back(int'(hr));
        if (hum_q.size() == WIN) begin
          exp_n1 = scale(hum_q.sum() / WIN, 100, 100);
          hum_q.delete();
        end
      end
      if (bv) begin
        bat_q.push_back(int'(br));
        if (bat_q.size() == WIN) begin
          exp_n2 = scale(bat_q.sum() / WIN, VREF_MV, 65535);
          bat_q.delete();
        end
      end
    end
    @(negedge clk);
    tick_no++;
    if (update_o) begin
      upd_cnt++;
      upd_ticks.push_back(tick_no);
      upd_vals.push_back(int'(number1));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1'b0, 12'd0, 1'b0, 12'd0);
  endtask

  initial begin
    // Reset state
    reset = 1'b1;
    idle(3);
    check("rst_number1", 32'(number1), 32'd0);
    check("rst_number2", 32'(number2), 32'd0);
    check("rst_ready", 32'(ready_o), 32'd0);
    check("rst_update", 32'(update_o), 32'd0);

    // Power-up: ready after exactly PU edges with reset low
    reset = 1'b0;
    for (int k = 1; k <= PU + 4; k++) begin
      idle(1);
      check($sformatf("ready_edge%0d", k), 32'(ready_o), (k >= PU) ? 32'd1 : 32'd0);
    end
    check("pu_number1", 32'(number1), 32'd0);
    check("pu_number2", 32'(number2), 32'd0);

    // Humidity mid-scale
    upd_cnt = 0;
    for (int i = 0; i < 8; i++) tick(1'b1, 12'd2048, 1'b0, 12'd0);
    idle(1);
    check("hum50_k1_update", 32'(update_o), 32'd0);
    check("hum50_k1_number1", 32'(number1), 32'd0);
    idle(1);
    check("hum50_k2_number1", 32'(number1), 32'd50);
    check("hum50_k2_update", 32'(update_o), 32'd1);
    idle(3);
    check("hum50_pulses", 32'(upd_cnt), 32'd1);

    // Battery full-scale, then humidity clamp path
    for (int i = 0; i < 8; i++) tick(1'b0, 12'd0, 1'b1, 12'd4095);
    idle(2);
    check("bat_full_number2", 32'(number2), 32'd3299);
    check("bat_full_number1_held", 32'(number1), 32'd50);
    idle(2);
    for (int i = 0; i < 8; i++) tick(1'b1, 12'd4095, 1'b0, 12'd0);
    idle(2);
    check("hum_full_number1", 32'(number1), 32'd100);
    idle(2);

    // Simultaneous completion
    for (int i = 0; i < 8; i++) tick(1'b1, 12'd1024, 1'b1, 12'd2048);
    idle(1);
    idle(1);
    check("sim_k2_number1", 32'(number1), 32'd25);
    check("sim_k2_update", 32'(update_o), 32'd1);
    check("sim_k2_number2_old", 32'(number2), 32'd3299);
    idle(1);
    check("sim_k3_number2", 32'(number2), 32'd1650);
    check("sim_k3_update", 32'(update_o), 32'd1);
    idle(1);
    check("sim_k4_update", 32'(update_o), 32'd0);

    // Reset mid-window discards partial sum
    for (int i = 0; i < 5; i++) tick(1'b1, 12'd0, 1'b0, 12'd0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("rmw_number1_cleared", 32'(number1), 32'd0);
    check("rmw_number2_cleared", 32'(number2), 32'd0);
    upd_cnt = 0;
    for (int i = 0; i < 7; i++) tick(1'b1, 12'd4095, 1'b0, 12'd0);
    idle(3);
    check("rmw_no_early_update", 32'(upd_cnt), 32'd0);
    tick(1'b1, 12'd4095, 1'b0, 12'd0);
    idle(2);
    check("rmw_number1", 32'(number1), 32'd100);
    check("rmw_pulses", 32'(upd_cnt), 32'd1);
    idle(2);

    // Back-to-back windows
    upd_ticks.delete();
    upd_vals.delete();
    start_tick = tick_no;
    for (int i = 0; i < 8; i++) tick(1'b1, 12'd0, 1'b0, 12'd0);
    for (int i = 0; i < 8; i++) tick(1'b1, 12'd4095, 1'b0, 12'd0);
    idle(4);
    check("b2b_pulse_count", 32'(upd_ticks.size()), 32'd2);
    if (upd_ticks.size() >= 2) begin
      check("b2b_first_at", 32'(upd_ticks[0] - start_tick), 32'd10);
      check("b2b_second_at", 32'(upd_ticks[1] - start_tick), 32'd18);
      check("b2b_first_val", 32'(upd_vals[0]), 32'd0);
      check("b2b_second_val", 32'(upd_vals[1]), 32'd100);
    end

    // Randomized traffic against the averaging model
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 48; c++) begin
        if ($urandom_range(0, 199) == 0) begin
          reset = 1'b1;
          idle(1);
          reset = 1'b0;
        end else begin
          tick(($urandom_range(0, 3) != 0), 12'($urandom_range(0, 4095)),
               ($urandom_range(0, 2) != 0), 12'($urandom_range(0, 4095)));
        end
      end
      idle(6);
      check($sformatf("rand%0d_number1", r), 32'(number1), 32'(exp_n1));
      check($sformatf("rand%0d_number2", r), 32'(number2), 32'(exp_n2));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_sensor_display_feeder
